// File: rtl/exp_req_ctrl.sv
// Exception request controller: synchronizes three external event lines, latches edges
// as pending, and runs a one-hot request/take/return handshake with CP0. Nesting via EXP_REQ_NEST_EN.
module exp_req_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] irq_in,
    input  logic [2:0] irq_mask,
    input  logic       ExpBlock,
    input  logic       HasExp,
    input  logic       IsEret,
    output logic       ExpSrc0,
    output logic       ExpSrc1,
    output logic       ExpSrc2,
    output logic [2:0] pending,
    output logic [2:0] in_service
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic [2:0] sync1_q, sync2_q, hist_q;
    logic [2:0] arm_q, arm_d;
    logic [1:0] fill_q, fill_d;
    logic [2:0] pending_q, pending_d;
    logic [2:0] in_service_q, in_service_d;
    logic [2:0] exp_src_q, exp_src_d;
    logic [1:0] sel_q, sel_d;

    logic [2:0] edge_det;
    logic [2:0] eligible;
    logic [2:0] take_clr;

    function automatic logic [1:0] top_idx(input logic [2:0] v);
        if (v[2])      return 2'd2;
        else if (v[1]) return 2'd1;
        else           return 2'd0;
    endfunction

    function automatic logic [2:0] onehot(input logic [1:0] idx);
        return 3'b001 << idx;
    endfunction

    // A line must be seen low after the synchronizer refills from reset before its
    // edges count, so a line held high across reset does not look like a fresh event.
    assign fill_d   = (fill_q == 2'd2) ? 2'd2 : fill_q + 2'd1;
    assign arm_d    = arm_q | ({3{fill_q == 2'd2}} & ~sync2_q);
    assign edge_det = sync2_q & ~hist_q & arm_q;
    assign eligible = pending_q & ~irq_mask;

    // NOTE: every output of this block gets a default first, so no path leaves a latch.
    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        exp_src_d    = exp_src_q;
        in_service_d = in_service_q;
        take_clr     = 3'b000;

        unique case (state_q)
            ST_IDLE: begin
                exp_src_d = 3'b000;
                if (eligible != 3'b000 && !ExpBlock) begin
                    state_d   = ST_REQ;
                    sel_d     = top_idx(eligible);
                    exp_src_d = onehot(top_idx(eligible));
                end
            end
            ST_REQ: begin
                if (HasExp) begin
                    take_clr     = onehot(sel_q);
                    in_service_d = in_service_q | onehot(sel_q);
                    exp_src_d    = 3'b000;
                    state_d      = ST_SERVICE;
                end else if (irq_mask[sel_q] || ExpBlock) begin
                    exp_src_d = 3'b000;
                    state_d   = (in_service_q != 3'b000) ? ST_SERVICE : ST_IDLE;
                end
            end
            ST_SERVICE: begin
                exp_src_d = 3'b000;
                if (IsEret) begin
                    in_service_d = in_service_q & ~onehot(top_idx(in_service_q));
                    if (in_service_d == 3'b000)
                        state_d = ST_IDLE;
                end
`ifdef EXP_REQ_NEST_EN
                else begin
                    logic [2:0] above;
                    logic [2:0] cand;
                    unique case (top_idx(in_service_q))
                        2'd2:    above = 3'b000;
                        2'd1:    above = 3'b100;
                        default: above = 3'b110;
                    endcase
                    cand = eligible & above;
                    if (cand != 3'b000 && !ExpBlock) begin
                        state_d   = ST_REQ;
                        sel_d     = top_idx(cand);
                        exp_src_d = onehot(top_idx(cand));
                    end
                end
`else
`endif
            end
            default: begin
                state_d   = ST_IDLE;
                exp_src_d = 3'b000;
            end
        endcase

        // A new edge wins over the take that clears the same bit.
        pending_d = (pending_q & ~take_clr) | edge_det;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            sync1_q      <= 3'b000;
            sync2_q      <= 3'b000;
            hist_q       <= 3'b000;
            arm_q        <= 3'b000;
            fill_q       <= 2'd0;
            pending_q    <= 3'b000;
            in_service_q <= 3'b000;
            exp_src_q    <= 3'b000;
            sel_q        <= 2'd0;
        end else begin
            state_q      <= state_d;
            sync1_q      <= irq_in;
            sync2_q      <= sync1_q;
            hist_q       <= sync2_q;
            arm_q        <= arm_d;
            fill_q       <= fill_d;
            pending_q    <= pending_d;
            in_service_q <= in_service_d;
            exp_src_q    <= exp_src_d;
            sel_q        <= sel_d;
        end
    end

    assign ExpSrc0    = exp_src_q[0];
    assign ExpSrc1    = exp_src_q[1];
    assign ExpSrc2    = exp_src_q[2];
    assign pending    = pending_q;
    assign in_service = in_service_q;

endmodule

// File: tb/tb_exp_req_ctrl.sv
// Directed bench for exp_req_ctrl; expected values hand-derived from the handshake timing.
module tb_exp_req_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] irq_in;
    logic [2:0] irq_mask;
    logic       ExpBlock;
    logic       HasExp;
    logic       IsEret;
    logic       ExpSrc0, ExpSrc1, ExpSrc2;
    logic [2:0] pending;
    logic [2:0] in_service;
    logic [2:0] exp_src;

    int checks = 0;
    int errors = 0;

    exp_req_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .irq_in     (irq_in),
        .irq_mask   (irq_mask),
        .ExpBlock   (ExpBlock),
        .HasExp     (HasExp),
        .IsEret     (IsEret),
        .ExpSrc0    (ExpSrc0),
        .ExpSrc1    (ExpSrc1),
        .ExpSrc2    (ExpSrc2),
        .pending    (pending),
        .in_service (in_service)
    );

    assign exp_src = {ExpSrc2, ExpSrc1, ExpSrc0};

    always #5 clk = ~clk;

    // Advance one rising edge; inputs change and outputs are sampled 1 time unit after it.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, expv);
        end
    endtask

    task automatic take_and_return();
        HasExp = 1'b1; tick(); HasExp = 1'b0;
        IsEret = 1'b1; tick(); IsEret = 1'b0;
    endtask

    initial begin
        reset = 1'b0; irq_in = 3'b000; irq_mask = 3'b000;
        ExpBlock = 1'b0; HasExp = 1'b0; IsEret = 1'b0;
        tick(3);
        check("rst_expsrc", exp_src, 3'b000);
        check("rst_pending", pending, 3'b000);
        check("rst_in_service", in_service, 3'b000);
        reset = 1'b1;
        tick(4);

        // Single source 0: three-edge latency to pending, request on the next edge.
        irq_in = 3'b001;
        tick(2);
        check("s0_pend_early", pending, 3'b000);
        tick();
        check("s0_pend", pending, 3'b001);
        check("s0_nореq_yet", exp_src, 3'b000);
        tick();
        check("s0_req", exp_src, 3'b001);
        HasExp = 1'b1; tick(); HasExp = 1'b0;
        check("s0_take_insvc", in_service, 3'b001);
        check("s0_take_expsrc", exp_src, 3'b000);
        check("s0_take_pend", pending, 3'b000);
        IsEret = 1'b1; tick(); IsEret = 1'b0;
        check("s0_eret", in_service, 3'b000);
        irq_in = 3'b000;
        tick(4);

        // Simultaneous 1 and 0: source 1 first, source 0 after one idle cycle.
        irq_in = 3'b011;
        tick(3);
        check("p10_pend", pending, 3'b011);
        tick();
        check("p10_req1", exp_src, 3'b010);
        HasExp = 1'b1; tick(); HasExp = 1'b0;
        check("p10_insvc1", in_service, 3'b010);
        check("p10_pend_left", pending, 3'b001);
        IsEret = 1'b1; tick(); IsEret = 1'b0;
        check("p10_idle_gap", exp_src, 3'b000);
        tick();
        check("p10_req0", exp_src, 3'b001);
        take_and_return();
        irq_in = 3'b000;
        tick(4);

        // Masked event stays latched but is not requested until unmasked.
        irq_mask = 3'b001;
        irq_in = 3'b001;
        tick(5);
        check("mask_pend", pending, 3'b001);
        check("mask_noreq", exp_src, 3'b000);
        irq_mask = 3'b000;
        tick();
        check("unmask_req", exp_src, 3'b001);
        take_and_return();
        irq_in = 3'b000;
        tick(4);

        // ExpBlock withdraws an asserted request; release re-issues it.
        irq_in = 3'b100;
        tick(4);
        check("blk_req2", exp_src, 3'b100);
        ExpBlock = 1'b1;
        tick();
        check("blk_withdraw", exp_src, 3'b000);
        check("blk_pend", pending, 3'b100);
        tick();
        check("blk_hold", exp_src, 3'b000);
        ExpBlock = 1'b0;
        tick();
        check("blk_reissue", exp_src, 3'b100);
        take_and_return();
        check("blk_done", in_service, 3'b000);
        irq_in = 3'b000;
        tick(4);

        // Source 2 event while source 0 is in service.
        irq_in = 3'b001;
        tick(4);
        HasExp = 1'b1; tick(); HasExp = 1'b0;
        check("svc0_insvc", in_service, 3'b001);
        irq_in = 3'b101;
        tick(3);
        check("svc0_pend2", pending, 3'b100);
`ifdef EXP_REQ_NEST_EN
        tick();
        check("nest_req2", exp_src, 3'b100);
        HasExp = 1'b1; tick(); HasExp = 1'b0;
        check("nest_insvc", in_service, 3'b101);
        IsEret = 1'b1; tick();
        check("nest_eret1", in_service, 3'b001);
        tick(); IsEret = 1'b0;
        check("nest_eret2", in_service, 3'b000);
        tick();
        check("nest_idle", exp_src, 3'b000);
`else
        tick();
        check("nonest_noreq", exp_src, 3'b000);
        check("nonest_pend", pending, 3'b100);
        IsEret = 1'b1; tick(); IsEret = 1'b0;
        check("nonest_eret", in_service, 3'b000);
        check("nonest_gap", exp_src, 3'b000);
        tick();
        check("nonest_req2", exp_src, 3'b100);
        take_and_return();
`endif
        irq_in = 3'b000;
        tick(4);

        // Edge on source 1 lands in the same cycle as its take: pending survives.
        irq_in = 3'b010;
        tick(4);
        check("race_req1", exp_src, 3'b010);
        irq_in = 3'b000;
        tick(3);
        check("race_held", exp_src, 3'b010);
        irq_in = 3'b010;
        tick(2);
        HasExp = 1'b1; tick(); HasExp = 1'b0;
        check("race_pend", pending, 3'b010);
        check("race_insvc", in_service, 3'b010);
        IsEret = 1'b1; tick(); IsEret = 1'b0;
        tick();
        check("race_req_again", exp_src, 3'b010);
        take_and_return();
        irq_in = 3'b000;
        tick(4);

        // Reset during a request with all lines held high.
        irq_in = 3'b111;
        tick(4);
        check("rreq_req2", exp_src, 3'b100);
        reset = 1'b0;
        tick();
        check("rreq_expsrc", exp_src, 3'b000);
        check("rreq_pend", pending, 3'b000);
        check("rreq_insvc", in_service, 3'b000);
        reset = 1'b1;
        tick(8);
        check("rrel_noreq", exp_src, 3'b000);
        check("rrel_nopend", pending, 3'b000);
        irq_in = 3'b110;
        tick(3);
        irq_in = 3'b111;
        tick(3);
        check("rrel_fresh_pend", pending, 3'b001);
        tick();
        check("rrel_fresh_req", exp_src, 3'b001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/exp_req_ctrl.md
EXP_REQ_CTRL -- requirements
Module: exp_req_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous, active-low.
REQ-003 SHALL have port irq_in, input, 3, raw asynchronous external event lines; bit n maps to source n.
REQ-004 SHALL have port irq_mask, input, 3; 1 = source n not eligible for request.
REQ-005 SHALL have port ExpBlock, input, 1, CP0 global exception block; 1 = no new request issued.
REQ-006 SHALL have port HasExp, input, 1, CP0 take acknowledge; sampled at rising clk edge.
REQ-007 SHALL have port IsEret, input, 1, return-from-exception indication; sampled at rising clk edge.
REQ-008 SHALL have ports ExpSrc0, ExpSrc1, ExpSrc2, output, 1 each, registered one-hot exception request lines to CP0.
REQ-009 SHALL have port pending, output, 3, latched-but-not-taken events.
REQ-010 SHALL have port in_service, output, 3, taken-but-not-returned sources.

Function
REQ-011 SHALL pass each irq_in bit through a 2-flop synchronizer, then a rising-edge detector; detected edge sets pending[n] on the 3rd rising clk edge after irq_in rises.
REQ-012 SHALL set pending[n] on edges regardless of irq_mask; masked pending bits stay latched, not eligible.
REQ-013 SHALL compute eligible = pending & ~irq_mask; request only when ExpBlock = 0.
REQ-014 SHALL implement FSM states IDLE, REQ, SERVICE; encoding free.
REQ-015 IDLE: if any eligible and ExpBlock = 0 -> REQ next edge; sel latched = highest eligible index (2 > 1 > 0).
REQ-016 REQ: ExpSrc[sel] = 1, other ExpSrc = 0; sel and outputs held constant (no re-prioritisation) until exit.
REQ-017 REQ, HasExp = 1: clear pending[sel], set in_service[sel], all ExpSrc = 0 next edge, -> SERVICE.
REQ-018 REQ, HasExp = 0 and (irq_mask[sel] = 1 or ExpBlock = 1): withdraw, all ExpSrc = 0, pending kept, -> IDLE.
REQ-019 SERVICE: IsEret = 1 clears highest set in_service bit; -> IDLE when in_service becomes 0.
REQ-020 IsEret in IDLE or REQ SHALL be ignored; HasExp outside REQ SHALL be ignored.
REQ-021 Edge on source n in the same cycle pending[n] is cleared by take: set wins (pending[n] = 1 after).
REQ-022 ExpSrc SHALL be all 0 for at least one full cycle between successive requests (guarantees new rising edge at CP0).
REQ-023 At most one ExpSrc bit SHALL be 1 in any cycle.

Reset
REQ-024 reset = 0 at rising edge SHALL force: state IDLE, synchronizers/edge history 0, pending = 0, in_service = 0, ExpSrc0..2 = 0.
REQ-025 Reset mid-REQ or mid-SERVICE SHALL abort without completing handshake; irq_in held high across reset SHALL NOT create an edge until it falls and rises again.

Configuration
REQ-026 Macro EXP_REQ_NEST_EN SHALL select nesting.
REQ-027 With EXP_REQ_NEST_EN: in SERVICE, eligible source with index strictly above highest in_service bit and ExpBlock = 0 -> REQ (nested); ERET returns to SERVICE while in_service != 0.
REQ-028 Without EXP_REQ_NEST_EN: SERVICE exits only via ERET; new events stay pending; in_service has at most one bit set.

Verification
REQ-029 irq_in[0] rise, mask 0 -> pending = 001 after 3 edges, ExpSrc0 = 1 next edge; HasExp = 1 -> in_service = 001, ExpSrc = 000.
REQ-030 irq_in = 011 rise same cycle -> ExpSrc1 first; after take + ERET + one idle cycle, ExpSrc0 = 1.
REQ-031 ExpSrc2 asserted in REQ, raise ExpBlock -> ExpSrc = 000, pending = 100, state IDLE; drop ExpBlock -> ExpSrc2 = 1 again.
REQ-032 In SERVICE (src0), irq_in[2] rise: with EXP_REQ_NEST_EN -> ExpSrc2 = 1, after take in_service = 101, two ERETs -> 000; without -> ExpSrc stays 000, pending = 100 until ERET.
REQ-033 irq_in[1] rise in same cycle as HasExp for src1 -> pending[1] = 1, second request issued after ERET.
REQ-034 reset = 0 during REQ with irq_in = 111 held -> all outputs 0; no request after reset release until a fresh rising edge.
